ram_trace_packetizer: RTL

//  Turns sampled PSRAM bus events into a time-stamped packet stream (address, write, read, timestamp).

---
 rtl/ram_trace_packetizer_pkg.sv | 15 +
 rtl/ram_trace_packetizer_if.sv | 26 ++
 rtl/ram_trace_packetizer_fifo.sv | 78 +++++++
 rtl/ram_trace_packetizer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ram_trace_packetizer_pkg.sv
// Shared constants for the RAM trace packetizer: packet type codes and
// default burst latencies used when configuring the tracer.
package ram_trace_packetizer_pkg;

    // Packet type codes carried on out_type
    localparam logic [1:0] PKT_ADDR  = 2'b00;
    localparam logic [1:0] PKT_READ  = 2'b01;
    localparam logic [1:0] PKT_WRITE = 2'b10;
    localparam logic [1:0] PKT_TS    = 2'b11;

    // Typical PSRAM latencies in RAM clocks
    localparam int unsigned DEF_RD_LAT = 4;
    localparam int unsigned DEF_WR_LAT = 3;

endpackage

// File: rtl/ram_trace_packetizer_if.sv
// Packet output stream of the tracer: ready/valid handshake with a 2-bit
// packet type and an ADDR_W-bit payload.
//   master: drives out_type, out_payload, out_valid; receives out_ready
//   slave : receives out_type, out_payload, out_valid; drives out_ready
interface ram_trace_packetizer_if #(
    parameter int unsigned ADDR_W = 23
);
    logic [1:0]        out_type;
    logic [ADDR_W-1:0] out_payload;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_type,
        output out_payload,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_type,
        input  out_payload,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/ram_trace_packetizer_fifo.sv
// Synchronous FIFO with a registered head stage. Capacity is DEPTH entries
// counting the head register, so "full" reflects everything held.
// A push never bypasses to the head, giving a two-clock push-to-valid latency.
//   clk, rst   : clock, async active-high reset
//   push       : write push_data (caller guarantees !full || pop)
//   ready      : consumer accepts head when head_valid
//   full       : no free entry this cycle
//   head_valid : head register holds data
//   head_data  : registered head entry
module ram_trace_packetizer_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             full,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic             head_valid_q, head_valid_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_c;
    logic             mem_pop_c;

    // Pointer, count and head-stage next state
    always_comb begin
        pop_c        = head_valid_q && ready;
        mem_pop_c    = (mem_cnt_q != '0) && (!head_valid_q || pop_c);
        full         = (mem_cnt_q + CNT_W'(head_valid_q)) == CNT_W'(DEPTH);
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = mem_pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        mem_cnt_d    = mem_cnt_q + CNT_W'(push) - CNT_W'(mem_pop_c);
        head_valid_d = head_valid_q;
        head_d       = head_q;
        if (mem_pop_c) begin
            head_valid_d = 1'b1;
            head_d       = mem_q[rd_ptr_q];
        end else if (pop_c) begin
            head_valid_d = 1'b0;
        end
    end

    // Storage array needs no reset; occupancy is tracked by the counters
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    assign head_valid = head_valid_q;
    assign head_data  = head_q;
endmodule

// File: rtl/ram_trace_packetizer.sv
// Turns sampled PSRAM bus events into a time-stamped packet stream
// (address, write, read, timestamp) with an output FIFO and loss accounting.
//   mclk, reset          : clock, async active-high reset
//   cfg_enable/cfg_reads : trace enable, include read packets
//   cfg_rd_lat/wr_lat    : burst latencies in RAM clocks
//   s_*                  : sampler address/data/control and strobes
//   out_if (master)      : out_type/out_payload/out_valid/out_ready stream
//   drop_count, err_drop : saturating drop counter, per-drop pulse
//   burst_cycle          : current burst position
module ram_trace_packetizer
    import ram_trace_packetizer_pkg::*;
#(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BURST_W    = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  mclk,
    input  logic                  reset,
    input  logic                  cfg_enable,
    input  logic                  cfg_reads,
    input  logic [BURST_W-1:0]    cfg_rd_lat,
    input  logic [BURST_W-1:0]    cfg_wr_lat,
    input  logic [ADDR_W-1:0]     s_a,
    input  logic [DATA_W-1:0]     s_d,
    input  logic [DATA_W-1:0]     s_nd,
    input  logic [DATA_W/8-1:0]   s_be,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic                  s_addr_latch,
    input  logic                  s_strobe,
    input  logic                  s_nstrobe,
    ram_trace_packetizer_if.master out_if,
    output logic [15:0]           drop_count,
    output logic                  err_drop,
    output logic [BURST_W-1:0]    burst_cycle
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned TS_W  = ADDR_W - DATA_W - BE_W;
    localparam int unsigned PKT_W = 2 + ADDR_W;
    localparam int unsigned BW1   = BURST_W + 1;
    localparam logic [ADDR_W-1:0] TS_MAX = ADDR_W'((64'd1 << TS_W) - 64'd1);

    logic [ADDR_W-1:0]  ts_q, ts_d;
    logic [BURST_W-1:0] burst_cycle_q, burst_cycle_d;
    logic [15:0]        drop_count_q, drop_count_d;
    logic               err_drop_q, err_drop_d;

    logic [TS_W-1:0]    ts5_c;
    logic [ADDR_W-1:0]  rem_c;
    logic [ADDR_W-1:0]  ts_inc_c;
    logic               wr_ok_c, rd_ok_c;
    logic               cand_c, is_data_c, is_ts_c;
    logic [PKT_W-1:0]   cand_pkt_c;
    logic               full_c, pop_c, accept_c, drop_c;
    logic               head_valid;
    logic [PKT_W-1:0]   head_data;

    // Candidate packet selection, timestamp bookkeeping and drop accounting
    always_comb begin
        ts5_c      = (ts_q > TS_MAX) ? TS_MAX[TS_W-1:0] : ts_q[TS_W-1:0];
        rem_c      = ts_q - ADDR_W'(ts5_c);
        ts_inc_c   = (s_strobe && (ts_q != '1)) ? ts_q + ADDR_W'(1) : ts_q;
        // burst_cycle >= wr_lat-1 evaluated without underflow
        wr_ok_c    = ({1'b0, burst_cycle_q} + BW1'(1)) >= {1'b0, cfg_wr_lat};
        rd_ok_c    = burst_cycle_q >= cfg_rd_lat;
        cand_c     = 1'b0;
        is_data_c  = 1'b0;
        is_ts_c    = 1'b0;
        cand_pkt_c = '0;
        if (cfg_enable) begin
            if (s_strobe && s_addr_latch) begin
                cand_c     = 1'b1;
                cand_pkt_c = {PKT_ADDR, s_a};
            end else if (s_strobe && s_write && wr_ok_c) begin
                cand_c     = 1'b1;
                is_data_c  = 1'b1;
                cand_pkt_c = {PKT_WRITE, ts5_c, s_be, s_d};
            end else if (cfg_reads && s_nstrobe && s_read && rd_ok_c) begin
                cand_c     = 1'b1;
                is_data_c  = 1'b1;
                cand_pkt_c = {PKT_READ, ts5_c, s_be, s_nd};
            end else if (s_strobe && (burst_cycle_q == BURST_W'(1)) && (rem_c != '0)) begin
                cand_c     = 1'b1;
                is_ts_c    = 1'b1;
                cand_pkt_c = {PKT_TS, ts_q};
            end
        end

        // A full FIFO still accepts when the head leaves this cycle
        pop_c    = head_valid && out_if.out_ready;
        accept_c = cand_c && (!full_c || pop_c);
        drop_c   = cand_c && !accept_c;

        // Dropped data/TS packets keep their time so it reappears later
        ts_d = ts_q;
        if (cfg_enable) begin
            ts_d = ts_inc_c;
            if (is_data_c && accept_c) begin
                ts_d = rem_c;
            end else if (is_ts_c) begin
                ts_d = accept_c ? '0 : ts_q;
            end
        end

        burst_cycle_d = burst_cycle_q;
        if (s_strobe) begin
            if (s_addr_latch) begin
                burst_cycle_d = '0;
            end else if ((s_read || s_write) && (burst_cycle_q != '1)) begin
                burst_cycle_d = burst_cycle_q + BURST_W'(1);
            end
        end

        drop_count_d = drop_count_q;
        if (drop_c && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        err_drop_d = drop_c;
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            ts_q          <= '0;
            burst_cycle_q <= '0;
            drop_count_q  <= '0;
            err_drop_q    <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            burst_cycle_q <= burst_cycle_d;
            drop_count_q  <= drop_count_d;
            err_drop_q    <= err_drop_d;
        end
    end

    ram_trace_packetizer_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (mclk),
        .rst        (reset),
        .push       (accept_c),
        .push_data  (cand_pkt_c),
        .ready      (out_if.out_ready),
        .full       (full_c),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign out_if.out_valid   = head_valid;
    assign out_if.out_type    = head_data[PKT_W-1 -: 2];
    assign out_if.out_payload = head_data[ADDR_W-1:0];
    assign drop_count         = drop_count_q;
    assign err_drop           = err_drop_q;
    assign burst_cycle        = burst_cycle_q;
endmodule
